// File: rtl/ysyx_25030081_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_25030081_wbu -- writeback unit in front of the integer register file.
//
// Accepts completed instructions from execute over a valid/ready handshake.
// Non-loads are written one cycle after acceptance. Loads park in WAIT_MEM
// until the memory response pulse, then the selected byte/halfword/word is
// sign- or zero-extended and written. The register-file port
// (rf_wen/rf_waddr/rf_wdata) is driven straight from flops. commit pulses
// once per retired instruction, including writes to x0 or with rd_wen=0.
//
// Optional feature (macro WBU_LOAD_TIMEOUT_EN): a WAIT_MEM watchdog. After
// TIMEOUT_CYCLES cycles with no mem_rvalid the load retires without a write
// and load_timeout pulses. Without the macro, load_timeout is tied to 0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  execute -> WBU handshake
//   in_rd, in_rd_wen     destination register and its write enable
//   in_is_load           result comes from mem_rdata
//   in_load_fmt          load funct3 (lb/lh/lw/lbu/lhu)
//   in_addr_lo           low two bits of the load effective address
//   in_result            result for non-loads
//   mem_rvalid/mem_rdata one-cycle load response, aligned 32-bit word
//   rf_wen/waddr/wdata   register file write port (registered)
//   commit               one-cycle retire pulse
//   load_timeout         one-cycle watchdog pulse
// ---------------------------------------------------------------------------
module ysyx_25030081_wbu #(
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RF_ADDR_WIDTH-1:0] in_rd,
  input  logic                     in_rd_wen,
  input  logic                     in_is_load,
  input  logic [2:0]               in_load_fmt,
  input  logic [1:0]               in_addr_lo,
  input  logic [DATA_WIDTH-1:0]    in_result,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     rf_wen,
  output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic                     commit,
  output logic                     load_timeout
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_e;

  localparam logic [2:0] FMT_LB  = 3'b000;
  localparam logic [2:0] FMT_LH  = 3'b001;
  localparam logic [2:0] FMT_LBU = 3'b100;
  localparam logic [2:0] FMT_LHU = 3'b101;

  state_e                     state_q, state_d;
  logic [RF_ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic                       rd_wen_q, rd_wen_d;
  logic [2:0]                 fmt_q, fmt_d;
  logic [1:0]                 addr_lo_q, addr_lo_d;
  logic                       rf_wen_q, rf_wen_d;
  logic [RF_ADDR_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]      rf_wdata_q, rf_wdata_d;
  logic                       load_timeout_q, load_timeout_d;
  logic                       transfer;
  logic                       timeout_hit;

  // Select and extend the load data from the aligned response word.
  // Halfword selection uses only addr_lo[1]; misaligned halves are not split.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [2:0]            fmt,
    input logic [1:0]            addr_lo,
    input logic [DATA_WIDTH-1:0] rdata
  );
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (fmt)
      FMT_LB:  load_extend = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      FMT_LH:  load_extend = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      FMT_LBU: load_extend = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      FMT_LHU: load_extend = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_extend = rdata;  // lw and undefined codes: whole word
    endcase
  endfunction

  assign in_ready = (state_q != S_WAIT_MEM);
  assign transfer = in_valid && in_ready;

`ifdef WBU_LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign timeout_hit = (state_q == S_WAIT_MEM) && (wait_cnt_q == CNT_LIMIT);

  // Held at zero outside WAIT_MEM, so every entry starts from zero.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q != S_WAIT_MEM) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_LIMIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path
    // through the case statement can leave it unassigned and infer a latch.
    state_d        = state_q;
    rd_d           = rd_q;
    rd_wen_d       = rd_wen_q;
    fmt_d          = fmt_q;
    addr_lo_d      = addr_lo_q;
    rf_wen_d       = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    load_timeout_d = 1'b0;

    case (state_q)
      S_IDLE, S_WRITE: begin
        if (transfer) begin
          if (in_is_load) begin
            // Any mem_rvalid seen this cycle is stale; the response for this
            // load is only accepted from the next cycle on.
            state_d   = S_WAIT_MEM;
            rd_d      = in_rd;
            rd_wen_d  = in_rd_wen;
            fmt_d     = in_load_fmt;
            addr_lo_d = in_addr_lo;
          end else begin
            state_d    = S_WRITE;
            rf_waddr_d = in_rd;
            rf_wdata_d = in_result;
            rf_wen_d   = in_rd_wen && (in_rd != '0);
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT_MEM: begin
        // A response coinciding with the timeout limit still completes.
        if (mem_rvalid) begin
          state_d    = S_WRITE;
          rf_waddr_d = rd_q;
          rf_wdata_d = load_extend(fmt_q, addr_lo_q, mem_rdata);
          rf_wen_d   = rd_wen_q && (rd_q != '0);
        end else if (timeout_hit) begin
          state_d        = S_WRITE;
          load_timeout_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  // The latched load fields are reset as well, so a reset taken in WAIT_MEM
  // leaves nothing of the discarded load behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rd_q           <= '0;
      rd_wen_q       <= 1'b0;
      fmt_q          <= '0;
      addr_lo_q      <= '0;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      load_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_q           <= rd_d;
      rd_wen_q       <= rd_wen_d;
      fmt_q          <= fmt_d;
      addr_lo_q      <= addr_lo_d;
      rf_wen_q       <= rf_wen_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      load_timeout_q <= load_timeout_d;
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign load_timeout = load_timeout_q;
  // Every WRITE cycle retires exactly one instruction.
  assign commit       = (state_q == S_WRITE);

endmodule

// File: tb/tb_ysyx_25030081_wbu.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ysyx_25030081_wbu. Inputs are driven and outputs
// sampled 1 time unit after each rising edge. Directed scenarios cover the
// reset state, latency, back-to-back writes, x0 suppression, load
// extension, reset during WAIT_MEM and the timeout option; a randomized
// run compares against a reference model of the writeback rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ysyx_25030081_wbu;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_rd = '0;
  logic          in_rd_wen = 1'b0;
  logic          in_is_load = 1'b0;
  logic [2:0]    in_load_fmt = '0;
  logic [1:0]    in_addr_lo = '0;
  logic [DW-1:0] in_result = '0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          commit;
  logic          load_timeout;

  int checks = 0;
  int errors = 0;

  // Model of the last values presented on the write port (they hold).
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  always #5 clk = ~clk;

  ysyx_25030081_wbu #(
    .RF_ADDR_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_rd_wen   (in_rd_wen),
    .in_is_load  (in_is_load),
    .in_load_fmt (in_load_fmt),
    .in_addr_lo  (in_addr_lo),
    .in_result   (in_result),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .commit      (commit),
    .load_timeout(load_timeout)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference load result computed by shifting and masking integers.
  function automatic logic [31:0] ref_load(input logic [2:0] fmt,
                                           input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'h0000_00FF;
    h = (w >> (16 * (a / 2))) & 32'h0000_FFFF;
    case (fmt)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_addr = '0;
    last_data = '0;
    step();
  endtask

  task automatic drive_instr(input logic [AW-1:0] rd, input logic wen,
                             input logic is_load, input logic [2:0] fmt,
                             input logic [1:0] a, input logic [DW-1:0] res);
    in_valid    = 1'b1;
    in_rd       = rd;
    in_rd_wen   = wen;
    in_is_load  = is_load;
    in_load_fmt = fmt;
    in_addr_lo  = a;
    in_result   = res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_rf_wen: got %b expected 0", rf_wen); end
    if (rf_waddr !== '0) begin errors++; $display("FAIL reset_rf_waddr: got %h expected 0", rf_waddr); end
    if (rf_wdata !== '0) begin errors++; $display("FAIL reset_rf_wdata: got %h expected 0", rf_wdata); end
    if (commit !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", commit); end
    if (load_timeout !== 1'b0) begin errors++; $display("FAIL reset_load_timeout: got %b expected 0", load_timeout); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    drive_instr(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks += 4;
    if (rf_wen !== 1'b1) begin errors++; $display("FAIL single_wen: got %b expected 1", rf_wen); end
    if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_waddr: got %0d expected 5", rf_waddr); end
    if (rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL single_wdata: got %h expected 12345678", rf_wdata); end
    if (commit !== 1'b1) begin errors++; $display("FAIL single_commit: got %b expected 1", commit); end
    step();
    checks += 4;
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL single_wen_drop: got %b expected 0", rf_wen); end
    if (commit !== 1'b0) begin errors++; $display("FAIL single_commit_drop: got %b expected 0", commit); end
    if (rf_waddr !== 5'd5) begin errors++; $display("FAIL single_waddr_hold: got %0d expected 5", rf_waddr); end
    if (rf_wdata !== 32'h1234_5678) begin errors++; $display("FAIL single_wdata_hold: got %h expected 12345678", rf_wdata); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] res;
    for (int i = 1; i <= 3; i++) begin
      res = $urandom;
      drive_instr(AW'(i), 1'b1, 1'b0, 3'd0, 2'd0, res);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready); end
      step();
      checks += 4;
      if (rf_wen !== 1'b1) begin errors++; $display("FAIL b2b_wen[%0d]: got %b expected 1", i, rf_wen); end
      if (commit !== 1'b1) begin errors++; $display("FAIL b2b_commit[%0d]: got %b expected 1", i, commit); end
      if (rf_waddr !== AW'(i)) begin errors++; $display("FAIL b2b_waddr[%0d]: got %0d expected %0d", i, rf_waddr, i); end
      if (rf_wdata !== res) begin errors++; $display("FAIL b2b_wdata[%0d]: got %h expected %h", i, rf_wdata, res); end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (commit !== 1'b0) begin errors++; $display("FAIL b2b_idle_commit: got %b expected 0", commit); end
  endtask

  task automatic test_rd_zero();
    drive_instr(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEAD_BEEF);
    step();
    in_valid = 1'b0;
    checks += 2;
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_wen: got %b expected 0", rf_wen); end
    if (commit !== 1'b1) begin errors++; $display("FAIL x0_commit: got %b expected 1", commit); end
    step();
  endtask

  task automatic test_loads();
    // lb at byte 3 after a four-cycle wait
    drive_instr(5'd7, 1'b1, 1'b1, 3'b000, 2'd3, 32'h0);
    step();
    in_valid = 1'b0;
    checks += 2;
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL lb_accept_wen: got %b expected 0", rf_wen); end
    if (commit !== 1'b0) begin errors++; $display("FAIL lb_accept_commit: got %b expected 0", commit); end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL lb_wait_ready[%0d]: got %b expected 0", w, in_ready); end
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_0011;
    step();
    mem_rvalid = 1'b0;
    checks += 4;
    if (rf_wen !== 1'b1) begin errors++; $display("FAIL lb_wen: got %b expected 1", rf_wen); end
    if (commit !== 1'b1) begin errors++; $display("FAIL lb_commit: got %b expected 1", commit); end
    if (rf_waddr !== 5'd7) begin errors++; $display("FAIL lb_waddr: got %0d expected 7", rf_waddr); end
    if (rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wdata: got %h expected ffffff80", rf_wdata); end

    // lhu at halfword 2; a response in the accept cycle must be ignored
    drive_instr(5'd9, 1'b1, 1'b1, 3'b101, 2'd2, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    step();
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    checks += 2;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL lhu_early_rvalid_ready: got %b expected 0", in_ready); end
    if (commit !== 1'b0) begin errors++; $display("FAIL lhu_early_rvalid_commit: got %b expected 0", commit); end
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_0011;
    step();
    mem_rvalid = 1'b0;
    checks += 3;
    if (rf_wen !== 1'b1) begin errors++; $display("FAIL lhu_wen: got %b expected 1", rf_wen); end
    if (rf_waddr !== 5'd9) begin errors++; $display("FAIL lhu_waddr: got %0d expected 9", rf_waddr); end
    if (rf_wdata !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_wdata: got %h expected 000080ff", rf_wdata); end
    step();
  endtask

  task automatic test_reset_in_wait();
    drive_instr(5'd4, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready_during: got %b expected 1", in_ready); end
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL rst_wait_wen_during: got %b expected 0", rf_wen); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    checks += 3;
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL rst_wait_wen: got %b expected 0", rf_wen); end
    if (commit !== 1'b0) begin errors++; $display("FAIL rst_wait_commit: got %b expected 0", commit); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_timeout();
    drive_instr(5'd3, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
    step();
    in_valid = 1'b0;
`ifdef WBU_LOAD_TIMEOUT_EN
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 4 * TO + 8; c++) begin
        if (load_timeout === 1'b1) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL timeout_pulse: got no pulse expected one");
      end else begin
        checks += 2;
        if (commit !== 1'b1) begin errors++; $display("FAIL timeout_commit: got %b expected 1", commit); end
        if (rf_wen !== 1'b0) begin errors++; $display("FAIL timeout_wen: got %b expected 0", rf_wen); end
        step();
        checks += 3;
        if (load_timeout !== 1'b0) begin errors++; $display("FAIL timeout_single: got %b expected 0", load_timeout); end
        if (commit !== 1'b0) begin errors++; $display("FAIL timeout_idle_commit: got %b expected 0", commit); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL timeout_idle_ready: got %b expected 1", in_ready); end
      end
    end
`else
    for (int c = 0; c < 4 * TO; c++) begin
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL nowdt_ready[%0d]: got %b expected 0", c, in_ready); end
      if (load_timeout !== 1'b0) begin errors++; $display("FAIL nowdt_timeout[%0d]: got %b expected 0", c, load_timeout); end
      step();
    end
`endif
    do_reset();
  endtask

  // Output comparison for the randomized scenario only.
  task automatic sample_rand(input bit exp_commit, input bit exp_wen,
                             input bit exp_ready, input int n);
    checks += 6;
    if (commit !== exp_commit) begin errors++; $display("FAIL rand_commit[%0d]: got %b expected %b", n, commit, exp_commit); end
    if (rf_wen !== exp_wen) begin errors++; $display("FAIL rand_wen[%0d]: got %b expected %b", n, rf_wen, exp_wen); end
    if (rf_waddr !== last_addr) begin errors++; $display("FAIL rand_waddr[%0d]: got %0d expected %0d", n, rf_waddr, last_addr); end
    if (rf_wdata !== last_data) begin errors++; $display("FAIL rand_wdata[%0d]: got %h expected %h", n, rf_wdata, last_data); end
    if (in_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, in_ready, exp_ready); end
    if (load_timeout !== 1'b0) begin errors++; $display("FAIL rand_timeout[%0d]: got %b expected 0", n, load_timeout); end
  endtask

  task automatic test_random();
    logic [AW-1:0] rd;
    logic          wen, is_load;
    logic [2:0]    fmt;
    logic [1:0]    a;
    logic [DW-1:0] res, word;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      // idle gap, with stray memory responses that must be ignored
      repeat ($urandom_range(0, 2)) begin
        in_valid   = 1'b0;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        step();
        mem_rvalid = 1'b0;
        sample_rand(1'b0, 1'b0, 1'b1, n);
      end
      rd      = AW'($urandom_range(0, 31));
      wen     = 1'($urandom_range(0, 3) != 0);
      is_load = 1'($urandom_range(0, 1));
      fmt     = 3'($urandom_range(0, 7));
      a       = 2'($urandom_range(0, 3));
      res     = $urandom;
      drive_instr(rd, wen, is_load, fmt, a, res);
      if (!is_load) begin
        step();
        in_valid  = 1'b0;
        last_addr = rd;
        last_data = res;
        sample_rand(1'b1, wen && (rd != 0), 1'b1, n);
      end else begin
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        step();
        mem_rvalid = 1'b0;
        in_valid   = 1'b0;
        sample_rand(1'b0, 1'b0, 1'b0, n);
        repeat ($urandom_range(0, 4)) begin
          in_valid = 1'($urandom_range(0, 1));
          step();
          in_valid = 1'b0;
          sample_rand(1'b0, 1'b0, 1'b0, n);
        end
        word       = $urandom;
        in_valid   = 1'($urandom_range(0, 1));
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        step();
        mem_rvalid = 1'b0;
        in_valid   = 1'b0;
        last_addr  = rd;
        last_data  = ref_load(fmt, a, word);
        sample_rand(1'b1, wen && (rd != 0), 1'b1, n);
      end
    end
    step();
  endtask

  initial begin
    last_addr = '0;
    last_data = '0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_rd_zero();
    test_loads();
    test_reset_in_wait();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_wbu.md
Name: ysyx_25030081_wbu

Overview:
Writeback unit directly upstream of the integer register file. It accepts completed instructions from the execute stage over a valid/ready handshake and waits for the memory read response on loads. It sign- or zero-extends load data and drives the register file's single write port (wen/waddr/wdata) with registered outputs. It also emits a one-cycle commit pulse per retired instruction.

Parameters:
RF_ADDR_WIDTH, 5, register index width; must match the register file.
DATA_WIDTH, 32, datapath width; load extension logic is defined for 32 only.
TIMEOUT_CYCLES, 255, WAIT_MEM cycle limit; used only when WBU_LOAD_TIMEOUT_EN is defined.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  execute stage presents an instruction.
in_ready  out  1  WBU can accept the instruction; transfer occurs when in_valid && in_ready at a rising edge.
in_rd  in  RF_ADDR_WIDTH  destination register.
in_rd_wen  in  1  instruction writes rd.
in_is_load  in  1  instruction is a load; the result comes from mem_rdata.
in_load_fmt  in  3  load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
in_addr_lo  in  2  low bits of the load effective address.
in_result  in  DATA_WIDTH  ALU/CSR/link result for non-loads.
mem_rvalid  in  1  one-cycle pulse carrying the load response.
mem_rdata  in  DATA_WIDTH  aligned 32-bit word containing the load data.
rf_wen  out  1  register file write enable.
rf_waddr  out  RF_ADDR_WIDTH  register file write address.
rf_wdata  out  DATA_WIDTH  register file write data.
commit  out  1  one-cycle pulse per retired instruction.
load_timeout  out  1  one-cycle error pulse; constant 0 when the optional feature is off.

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0 except in_ready, which is 1. State goes to IDLE and any held instruction or pending load is discarded. Reset may assert in any state, including WAIT_MEM.
- States:
  - IDLE: no instruction held.
  - WAIT_MEM: a load is accepted and its data is outstanding.
  - WRITE: the rf_* outputs are valid for exactly this one cycle.
- in_ready = (state != WAIT_MEM), combinational from the state register.
- Transitions:
  - IDLE or WRITE, with a transfer and in_is_load=0: go to WRITE next cycle. Register rf_waddr=in_rd, rf_wdata=in_result, rf_wen = in_rd_wen && (in_rd != 0).
  - IDLE or WRITE, with a transfer and in_is_load=1: go to WAIT_MEM. Latch rd, rd_wen, fmt and addr_lo. rf_wen=0 next cycle.
  - WAIT_MEM with mem_rvalid=1: go to WRITE. rf_wdata = extended data, rf_wen = latched rd_wen && (rd != 0).
  - WAIT_MEM with mem_rvalid=0: stay in WAIT_MEM.
  - WRITE with no transfer: go to IDLE. rf_wen=0, commit=0.
- Latency:
  - Non-load accepted at edge N: rf_wen/commit are high during cycle N+1.
  - Load whose mem_rvalid is sampled at edge M: outputs are high during cycle M+1.
  - Back-to-back non-loads sustain one write per cycle.
- commit is 1 exactly when the state is WRITE, including when rd=0 or rd_wen=0 (write suppressed, instruction still retires).
- rf_waddr and rf_wdata hold their last values when rf_wen=0.
- Load extension:
  - Byte select is mem_rdata[8*addr_lo +: 8].
  - Halfword select is mem_rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - fmt 010 and the undefined codes 011, 110, 111 return the full word.
- mem_rvalid in IDLE or WRITE is spurious and is ignored with no state change.
- mem_rvalid arriving in the same cycle the load is accepted is ignored; the response must arrive at least one cycle later.
- in_valid deasserted while in WAIT_MEM has no effect.

Optional Feature:
- Macro: WBU_LOAD_TIMEOUT_EN.
- Defined:
  - A counter of width ceil(log2(TIMEOUT_CYCLES+1)) clears on entry to WAIT_MEM and increments each cycle in WAIT_MEM.
  - When it reaches TIMEOUT_CYCLES with no mem_rvalid, load_timeout pulses for one cycle and the state goes to WRITE with rf_wen=0. commit still pulses, so the pipeline cannot hang.
  - mem_rvalid in the same cycle as the limit wins, and the load completes normally.
- Not defined: no counter is built, load_timeout is tied 0, and WAIT_MEM waits indefinitely.

Test Plan:
- Reset release, then a non-load rd=5, result=0x1234_5678, rd_wen=1 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x12345678, commit=1; the cycle after, rf_wen=0.
- Three back-to-back non-loads to x1, x2, x3 with in_valid held high -> in_ready stays 1; three consecutive cycles of rf_wen/commit with matching addresses.
- Non-load to rd=0 with rd_wen=1 -> rf_wen=0, commit=1.
- lb at addr_lo=3, mem_rdata=0x80FF_0011 after a 4-cycle wait -> in_ready=0 during the wait; rf_wdata=0xFFFFFF80. Then lhu at addr_lo=2 on the same word -> rf_wdata=0x000080FF.
- rst_n pulsed low while in WAIT_MEM, then mem_rvalid arrives -> no rf write, no commit; in_ready=1 after release.
- With WBU_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=8, a load with no response -> load_timeout=1 and commit=1 together, rf_wen=0, then IDLE. Without the macro, load_timeout stays 0 and in_ready stays 0.
